// File: rtl/decoder_pkg.sv
// Shared definitions for the 2-to-4 pulse decoder.
//   IDX_W / OUT_W : encoded index width and one-hot output width
//   CNT_W         : width of the hold/gap cycle counter
//   dec_state_e   : pulse FSM states (IDLE, HOLD, GAP)
//   idx_to_onehot : encoded index -> one-hot vector
package decoder_pkg;
  localparam int IDX_W = 2;
  localparam int OUT_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } dec_state_e;

  function automatic logic [OUT_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [OUT_W-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/decoder_2x4_pulse_timer.sv
// dec_pulse_timer: 8-bit loadable down-counter used to time pulse hold and
// gap phases. It stops at zero and reports done while the count is zero.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force count to zero (highest priority)
//   load       : load load_val this cycle
//   load_val   : value to load
//   done       : count == 0
module dec_pulse_timer
  import decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/decoder_2x4_pulse.sv
// decoder_2x4_pulse: turns a 2-bit index into a registered one-hot pulse that
// is held for HOLD_CYCLES and followed by GAP_CYCLES of forced zero. A
// one-deep pending slot accepts the next index while a pulse is in flight.
//   clk, rst_n : clock, synchronous active-low reset
//   E          : enable; low aborts any pulse, drops pending, blocks input
//   in_valid   : in_idx is valid
//   in_idx     : encoded index 0..3
//   in_ready   : index can be accepted this cycle
//   Y          : registered one-hot output (zero when idle or in gap)
//   y_valid    : |Y
//   busy       : FSM not idle or pending slot occupied
//   evt_count  : (only with DECODER_STATS_EN) per-index saturating count of
//                pulses started, 4 x 8 bits packed, indexed by idx
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state, rst_n and E, never on in_valid,
// and once in_valid is offered the source holds in_idx until the transfer.
module decoder_2x4_pulse
  import decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             in_ready,
  output logic [OUT_W-1:0] Y,
  output logic             y_valid,
  output logic             busy
`ifdef DECODER_STATS_EN
  ,
  output logic [OUT_W-1:0][CNT_W-1:0] evt_count
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam bit               HAS_GAP   = (GAP_CYCLES != 0);
  localparam logic [CNT_W-1:0] GAP_LOAD  = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;

  dec_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [OUT_W-1:0] y_q, y_d;

  logic             xfer;
  logic             have_next;
  logic [IDX_W-1:0] next_idx;
  logic             tmr_clr;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  dec_pulse_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  assign in_ready = rst_n && E && !pend_valid_q;
  assign xfer     = in_valid && in_ready;

  // A transfer on the last HOLD/GAP cycle is used directly at the phase
  // boundary, so the next pulse starts without an extra cycle in the slot.
  assign have_next = pend_valid_q || xfer;
  assign next_idx  = pend_valid_q ? pend_idx_q : in_idx;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_valid_d = pend_valid_q;
    pend_idx_d   = pend_idx_q;
    tmr_clr      = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    if (!E) begin
      // Abort wins over any counter expiry in the same cycle.
      state_d      = IDLE;
      pend_valid_d = 1'b0;
      tmr_clr      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            state_d  = HOLD;
            idx_d    = in_idx;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (xfer) begin
            pend_valid_d = 1'b1;
            pend_idx_d   = in_idx;
          end
          if (tmr_done) begin
            if (HAS_GAP) begin
              state_d  = GAP;
              tmr_load = 1'b1;
              tmr_val  = GAP_LOAD;
            end else if (have_next) begin
              // Back-to-back pulse: one-hot to one-hot with no zero cycle.
              state_d      = HOLD;
              idx_d        = next_idx;
              pend_valid_d = 1'b0;
              tmr_load     = 1'b1;
              tmr_val      = HOLD_LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        GAP: begin
          if (xfer) begin
            pend_valid_d = 1'b1;
            pend_idx_d   = in_idx;
          end
          if (tmr_done) begin
            if (have_next) begin
              state_d      = HOLD;
              idx_d        = next_idx;
              pend_valid_d = 1'b0;
              tmr_load     = 1'b1;
              tmr_val      = HOLD_LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d      = IDLE;
          pend_valid_d = 1'b0;
          tmr_clr      = 1'b1;
        end
      endcase
    end

    y_d = (state_d == HOLD) ? idx_to_onehot(idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      y_q          <= y_d;
    end
  end

  assign Y       = y_q;
  assign y_valid = |y_q;
  assign busy    = (state_q != IDLE) || pend_valid_q;

`ifdef DECODER_STATS_EN
  logic [OUT_W-1:0][CNT_W-1:0] evt_q, evt_d;
  logic                        pulse_start;

  always_comb begin
    // A pulse starts on entry to HOLD, or on a HOLD->HOLD restart at expiry.
    pulse_start = (state_d == HOLD) && ((state_q != HOLD) || tmr_done);
    evt_d       = evt_q;
    if (pulse_start && (evt_q[idx_d] != '1)) begin
      evt_d[idx_d] = evt_q[idx_d] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt_count = evt_q;
`endif

endmodule

// File: tb/tb_decoder_2x4_pulse.sv
// Bench for decoder_2x4_pulse. Two instances share clock and reset:
//   dut0: HOLD_CYCLES=2, GAP_CYCLES=1 (defaults)
//   dut1: HOLD_CYCLES=1, GAP_CYCLES=0 (back-to-back pulses)
// A cycle model tracks remaining hold/gap cycles and a pending index per
// instance and is compared against every output on every cycle; directed
// sequences add hand-computed literal checks.
module tb_decoder_2x4_pulse;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      e_s, iv_s, rdy_s, yv_s, busy_s;
  logic [1:0][1:0] idx_s;
  logic [1:0][3:0] y_s;
`ifdef DECODER_STATS_EN
  logic [1:0][3:0][7:0] evt_s;
`endif

  decoder_2x4_pulse #(.HOLD_CYCLES(2), .GAP_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .E(e_s[0]), .in_valid(iv_s[0]), .in_idx(idx_s[0]),
    .in_ready(rdy_s[0]), .Y(y_s[0]), .y_valid(yv_s[0]), .busy(busy_s[0])
`ifdef DECODER_STATS_EN
    , .evt_count(evt_s[0])
`endif
  );

  decoder_2x4_pulse #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .E(e_s[1]), .in_valid(iv_s[1]), .in_idx(idx_s[1]),
    .in_ready(rdy_s[1]), .Y(y_s[1]), .y_valid(yv_s[1]), .busy(busy_s[1])
`ifdef DECODER_STATS_EN
    , .evt_count(evt_s[1])
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int m_hold[2];
  int m_gap[2];
  int m_idx[2];
  bit m_pend_v[2];
  int m_pend_idx[2];
  int m_evt[2][4];

  function automatic int hold_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic model_step(input int k, input logic rn, input logic en, input logic v,
                            input logic [1:0] ix);
    bit accepted;
    if (!rn) begin
      m_hold[k] = 0; m_gap[k] = 0; m_idx[k] = 0; m_pend_v[k] = 0; m_pend_idx[k] = 0;
      for (int i = 0; i < 4; i++) m_evt[k][i] = 0;
    end else if (!en) begin
      m_hold[k] = 0; m_gap[k] = 0; m_pend_v[k] = 0;
    end else begin
      accepted = v && !m_pend_v[k];
      if (accepted) begin
        m_pend_v[k]   = 1;
        m_pend_idx[k] = ix;
      end
      if (m_hold[k] > 0) begin
        m_hold[k]--;
        if (m_hold[k] == 0) m_gap[k] = gap_of(k);
      end else if (m_gap[k] > 0) begin
        m_gap[k]--;
      end
      if (m_hold[k] == 0 && m_gap[k] == 0 && m_pend_v[k]) begin
        m_idx[k]    = m_pend_idx[k];
        m_pend_v[k] = 0;
        m_hold[k]   = hold_of(k);
        if (m_evt[k][m_idx[k]] < 255) m_evt[k][m_idx[k]]++;
      end
    end
  endtask

  // Step the model on each rising edge with the inputs present at that edge,
  // then compare every output shortly after.
  initial begin
    logic [31:0] exp_y;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, rst_n, e_s[k], iv_s[k], idx_s[k]);
      #1;
      for (int k = 0; k < 2; k++) begin
        exp_y = (m_hold[k] > 0) ? (32'd1 << m_idx[k]) : 32'd0;
        check("cyc_y", k, {28'd0, y_s[k]}, exp_y);
        check("cyc_y_valid", k, {31'd0, yv_s[k]}, {31'd0, (m_hold[k] > 0)});
        check("cyc_busy", k, {31'd0, busy_s[k]},
              {31'd0, (m_hold[k] > 0 || m_gap[k] > 0 || m_pend_v[k])});
        check("cyc_in_ready", k, {31'd0, rdy_s[k]},
              {31'd0, (rst_n && e_s[k] && !m_pend_v[k])});
`ifdef DECODER_STATS_EN
        for (int i = 0; i < 4; i++)
          check("cyc_evt", k, {24'd0, evt_s[k][i]}, m_evt[k][i]);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int k, input logic v, input logic [1:0] ix);
    iv_s[k]  = v;
    idx_s[k] = ix;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  logic [3:0] t4_exp [4];
  int         acc;
  int         cyc;

  initial begin
    t4_exp[0] = 4'b0001; t4_exp[1] = 4'b0010; t4_exp[2] = 4'b0100; t4_exp[3] = 4'b1000;
    rst_n = 1'b0;
    e_s   = 2'b11;
    iv_s  = 2'b00;
    idx_s = '0;

    // Reset: in_ready low while rst_n is low, idle outputs after release.
    repeat (3) tick();
    check("rst_ready_low", 0, {31'd0, rdy_s[0]}, 32'd0);
    check("rst_y", 0, {28'd0, y_s[0]}, 32'd0);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      check("post_rst_y", k, {28'd0, y_s[k]}, 32'd0);
      check("post_rst_y_valid", k, {31'd0, yv_s[k]}, 32'd0);
      check("post_rst_busy", k, {31'd0, busy_s[k]}, 32'd0);
      check("post_rst_ready", k, {31'd0, rdy_s[k]}, 32'd1);
    end

    // Single pulse, idx=2, defaults.
    drive(0, 1'b1, 2'd2);
    tick(); drive(0, 1'b0, 2'd0);
    check("single_n1", 0, {28'd0, y_s[0]}, 32'h4);
    tick(); check("single_n2", 0, {28'd0, y_s[0]}, 32'h4);
    tick(); check("single_n3_y", 0, {28'd0, y_s[0]}, 32'h0);
    check("single_n3_busy", 0, {31'd0, busy_s[0]}, 32'd1);
    tick(); check("single_n4_busy", 0, {31'd0, busy_s[0]}, 32'd0);
    repeat (2) tick();

    // Back-to-back idx=1 then idx=3 with defaults.
    drive(0, 1'b1, 2'd1);
    tick(); drive(0, 1'b1, 2'd3);
    check("b2b_k1_y", 0, {28'd0, y_s[0]}, 32'h2);
    check("b2b_k1_ready", 0, {31'd0, rdy_s[0]}, 32'd1);
    tick(); drive(0, 1'b0, 2'd0);
    check("b2b_k2_y", 0, {28'd0, y_s[0]}, 32'h2);
    check("b2b_k2_ready", 0, {31'd0, rdy_s[0]}, 32'd0);
    tick(); check("b2b_gap_y", 0, {28'd0, y_s[0]}, 32'h0);
    check("b2b_gap_ready", 0, {31'd0, rdy_s[0]}, 32'd0);
    tick(); check("b2b_k4_y", 0, {28'd0, y_s[0]}, 32'h8);
    tick(); check("b2b_k5_y", 0, {28'd0, y_s[0]}, 32'h8);
    tick(); check("b2b_k6_y", 0, {28'd0, y_s[0]}, 32'h0);
    check("b2b_k6_busy", 0, {31'd0, busy_s[0]}, 32'd1);
    tick(); check("b2b_k7_busy", 0, {31'd0, busy_s[0]}, 32'd0);
    repeat (2) tick();

    // Streaming with HOLD=1, GAP=0: no zero cycle between pulses.
    drive(1, 1'b1, 2'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("stream_y", 1, {28'd0, y_s[1]}, {28'd0, t4_exp[i]});
      if (i < 3) drive(1, 1'b1, 2'(i + 1));
      else drive(1, 1'b0, 2'd0);
      tick();
    end
    check("stream_end_y", 1, {28'd0, y_s[1]}, 32'h0);
    check("stream_end_busy", 1, {31'd0, busy_s[1]}, 32'd0);
    repeat (2) tick();

    // Abort mid-HOLD with pending full, then restart.
    drive(0, 1'b1, 2'd1);
    tick(); drive(0, 1'b1, 2'd2);
    tick(); drive(0, 1'b0, 2'd0);
    check("abort_pre_ready", 0, {31'd0, rdy_s[0]}, 32'd0);
    check("abort_pre_y", 0, {28'd0, y_s[0]}, 32'h2);
    e_s[0] = 1'b0;
    tick();
    check("abort_y", 0, {28'd0, y_s[0]}, 32'h0);
    check("abort_busy", 0, {31'd0, busy_s[0]}, 32'd0);
    check("abort_ready", 0, {31'd0, rdy_s[0]}, 32'd0);
    e_s[0] = 1'b1;
    drive(0, 1'b1, 2'd0);
    tick(); drive(0, 1'b0, 2'd0);
    check("restart_k1", 0, {28'd0, y_s[0]}, 32'h1);
    tick(); check("restart_k2", 0, {28'd0, y_s[0]}, 32'h1);
    tick(); check("restart_k3", 0, {28'd0, y_s[0]}, 32'h0);
    tick(); check("restart_idle", 0, {31'd0, busy_s[0]}, 32'd0);

    // Counter saturation: 300 pulses of idx=3 after a fresh reset.
    do_reset(2);
    drive(1, 1'b1, 2'd3);
    acc = 0;
    cyc = 0;
    while (acc < 300 && cyc < 2000) begin
      if (rdy_s[1]) acc++;
      tick();
      cyc++;
    end
    drive(1, 1'b0, 2'd0);
    check("sat_transfers", 1, acc, 32'd300);
    repeat (3) tick();
    check("sat_idle", 1, {31'd0, busy_s[1]}, 32'd0);
`ifdef DECODER_STATS_EN
    check("sat_evt3", 1, {24'd0, evt_s[1][3]}, 32'd255);
    check("sat_evt0", 1, {24'd0, evt_s[1][0]}, 32'd0);
    check("sat_evt1", 1, {24'd0, evt_s[1][1]}, 32'd0);
    check("sat_evt2", 1, {24'd0, evt_s[1][2]}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
